gshare_branch_predictor: RTL

Parametrised gshare direction predictor for each core in the soc, replacing the fixed per-core predict_taken / predict_history logic.
- Pattern history table (PHT) of saturating counters, indexed by PC XOR a global history register (GHR).
- GHR is updated speculatively on each lookup and repaired on a mispredict.
- Sits between the core fetch stage (lookup) and the execute stage (training).

---
 rtl/bp_pkg.sv | 20 ++
 rtl/bp_sat_counter_table.sv | 42 ++++
 rtl/gshare_branch_predictor.sv | 108 ++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared defaults and helper functions for the gshare branch predictor.
package bp_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int IDX_W_DEF  = 8;
    localparam int HIST_W_DEF = 8;
    localparam int CNT_W_DEF  = 2;
    localparam int HASH_W     = 16;

    // Weakly not-taken: one below the taken threshold.
    function automatic int cnt_reset_val(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    function automatic logic [HASH_W-1:0] gshare_hash(input logic [HASH_W-1:0] pc,
                                                      input logic [HASH_W-1:0] hist);
        return pc ^ hist;
    endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Pattern history table: saturating counters, one combinational read port and one update port.
module bp_sat_counter_table
    import bp_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_cnt,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_inc
);

    localparam int               DEPTH    = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_reset_val(CNT_W));
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] pht [DEPTH];
    logic [CNT_W-1:0] cur;

    // Read-before-write: the read sees the counter value before this edge's update.
    assign rd_cnt = pht[rd_idx];
    assign cur    = pht[upd_idx];

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= CNT_INIT;
            end
        end else if (upd_en) begin
            if (upd_inc && (cur != CNT_MAX)) begin
                pht[upd_idx] <= cur + 1'b1;
            end else if (!upd_inc && (cur != '0)) begin
                pht[upd_idx] <= cur - 1'b1;
            end
        end
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor: GHR, registered prediction, mispredict repair.
// Optional perf counters built only when BP_PERF_CNT_EN is defined.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int HIST_W = HIST_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              predict_valid,
    output logic              predict_taken,
    output logic [HIST_W-1:0] predict_history,
    input  logic              train_valid,
    input  logic [ADDR_W-1:0] train_pc,
    input  logic [HIST_W-1:0] train_history,
    input  logic              train_taken,
    input  logic              train_mispredicted,
    output logic [15:0]       perf_lookups,
    output logic [15:0]       perf_mispredicts
);

    logic [HIST_W-1:0] ghr;
    logic [IDX_W-1:0]  lookup_idx;
    logic [IDX_W-1:0]  train_idx;
    logic [CNT_W-1:0]  lookup_cnt;
    logic              pred_bit;
    logic              flush;
    logic              lookup_ok;
    logic [HIST_W:0]   spec_cat;
    logic [HIST_W:0]   repair_cat;
    logic              unused_bits;

    assign lookup_idx = IDX_W'(gshare_hash(HASH_W'(lookup_pc[IDX_W-1:0]), HASH_W'(ghr)));
    assign train_idx  = IDX_W'(gshare_hash(HASH_W'(train_pc[IDX_W-1:0]), HASH_W'(train_history)));
    assign pred_bit   = lookup_cnt[CNT_W-1];
    assign flush      = train_valid & train_mispredicted;
    assign lookup_ok  = lookup_valid & ~flush;

    // Dropping the top bit of the concatenation gives the shifted history for any HIST_W >= 1.
    assign spec_cat   = {ghr, pred_bit};
    assign repair_cat = {train_history, train_taken};

    assign unused_bits = ^{lookup_pc, train_pc};

    bp_sat_counter_table #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_pht (
        .CLK     (CLK),
        .RES     (RES),
        .rd_idx  (lookup_idx),
        .rd_cnt  (lookup_cnt),
        .upd_en  (train_valid),
        .upd_idx (train_idx),
        .upd_inc (train_taken)
    );

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            ghr             <= '0;
            predict_valid   <= 1'b0;
            predict_taken   <= 1'b0;
            predict_history <= '0;
        end else begin
            predict_valid <= lookup_ok;
            if (lookup_ok) begin
                predict_taken   <= pred_bit;
                predict_history <= ghr;
            end
            if (flush) begin
                ghr <= repair_cat[HIST_W-1:0];
            end else if (lookup_valid) begin
                ghr <= spec_cat[HIST_W-1:0];
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [15:0] lookups_q;
    logic [15:0] mispredicts_q;

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            lookups_q     <= '0;
            mispredicts_q <= '0;
        end else begin
            if (lookup_ok && (lookups_q != 16'hFFFF)) begin
                lookups_q <= lookups_q + 16'd1;
            end
            if (flush && (mispredicts_q != 16'hFFFF)) begin
                mispredicts_q <= mispredicts_q + 16'd1;
            end
        end
    end

    assign perf_lookups     = lookups_q;
    assign perf_mispredicts = mispredicts_q;
`else
    assign perf_lookups     = 16'd0;
    assign perf_mispredicts = 16'd0;
`endif

endmodule
